// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB4 completer memory.
//   apb_slv_state_e : two-state completer FSM encoding (IDLE, ACCESS)
//   PPROT_PRIV_BIT  : PPROT bit that marks a privileged access
//   strb_w()        : byte-strobe width for a given data width
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_slv_state_e;

    localparam int PPROT_PRIV_BIT = 0;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/apb_bytemem.sv
// Byte-lane writable word memory with a registered read port.
//   clk        in  : clock
//   i_rd_en    in  : load o_rd_data from i_rd_idx on this edge
//   i_rd_idx   in  : read word index
//   o_rd_data  out : registered read word (holds between read enables)
//   i_wr_en    in  : commit write on this edge
//   i_wr_idx   in  : write word index
//   i_wr_data  in  : write word
//   i_wr_strb  in  : per-byte write enables
// Contents are not reset.
module apb_bytemem #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_rd_en,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [STRB_W-1:0] i_wr_strb
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_idx];
        end
        if (i_wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wr_strb[b]) begin
                    r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/apb4_slave_mem.sv
// APB4 completer backed by a word-addressed memory with byte strobes,
// programmable wait states and PSLVERR generation.
//   clk          in  : clock
//   reset_n      in  : asynchronous active-low reset
//   sel          in  : PSEL
//   enable       in  : PENABLE
//   write        in  : PWRITE
//   addr         in  : PADDR (byte address)
//   wdata        in  : PWDATA
//   strb         in  : PSTRB byte-lane write enables
//   prot         in  : PPROT (only the privileged bit is used)
//   wait_cycles  in  : wait states inserted per transfer, sampled at setup
//   ready        out : PREADY
//   rdata        out : PRDATA
//   slvERR       out : PSLVERR, meaningful only while ready is high
module apb4_slave_mem
    import apb_pkg::*;
#(
    parameter int  ADDR_W     = 32,
    parameter int  DATA_W     = 32,
    parameter int  DEPTH      = 256,
    parameter int  PROT_WORDS = 16,
    parameter int  WAIT_W     = 4,
    localparam int STRB_W     = strb_w(DATA_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sel,
    input  logic              enable,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] strb,
    input  logic [2:0]        prot,
    input  logic [WAIT_W-1:0] wait_cycles,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              slvERR
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFS_W = $clog2(STRB_W);
    localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(STRB_W - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PROT_A   = ADDR_W'(PROT_WORDS);

    apb_slv_state_e    r_state;
    logic [WAIT_W-1:0] r_cnt;
    logic              r_write;
    logic              r_err;
    logic              r_rd_vld;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_strb;

    logic [ADDR_W-1:0] w_idx_full;
    logic              w_err;
    logic              w_setup;
    logic              w_complete;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_mem_rdata;
    logic              w_unused_prot;

    // Only the privileged bit matters; the rest are deliberately ignored.
    assign w_unused_prot = ^prot;

    // Full-width index so out-of-range addresses are caught before truncation.
    assign w_idx_full = addr >> OFS_W;

    assign w_err = ((addr & OFS_MASK) != '0)
                || (w_idx_full >= DEPTH_A)
                || (write && !prot[PPROT_PRIV_BIT] && (w_idx_full < PROT_A));

    assign w_setup    = (r_state == IDLE) && sel && !enable;
    assign w_complete = (r_state == ACCESS) && sel && enable && (r_cnt == '0);
    assign w_mem_we   = w_complete && r_write && !r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_rd_vld <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_setup) begin
                        r_state  <= ACCESS;
                        r_cnt    <= wait_cycles;
                        r_write  <= write;
                        r_err    <= w_err;
                        r_rd_vld <= !write && !w_err;
                    end
                end
                ACCESS: begin
                    if (!sel) begin
                        // Requester abandoned the transfer: nothing is written.
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (enable) begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - WAIT_W'(1);
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Transfer payload; no reset needed since it is only used after a setup.
    always_ff @(posedge clk) begin
        if (w_setup) begin
            r_idx   <= w_idx_full[IDX_W-1:0];
            r_wdata <= wdata;
            r_strb  <= strb;
        end
    end

    // Read is issued on the setup edge; out-of-range indices wrap here but
    // their data is masked by r_rd_vld.
    apb_bytemem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .STRB_W (STRB_W),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk       (clk),
        .i_rd_en   (w_setup),
        .i_rd_idx  (w_idx_full[IDX_W-1:0]),
        .o_rd_data (w_mem_rdata),
        .i_wr_en   (w_mem_we),
        .i_wr_idx  (r_idx),
        .i_wr_data (r_wdata),
        .i_wr_strb (r_strb)
    );

    assign ready  = (r_state == ACCESS) && (r_cnt == '0);
    assign slvERR = r_err && ready;
    assign rdata  = r_rd_vld ? w_mem_rdata : '0;

endmodule
